// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned OCC_W     = 2;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry {data,pc} FIFO between the ROM return and the decoder.
// The head entry is held in flops so the outputs never see rom_data combinationally.
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [DW-1:0]    data_i,
  input  logic [AW-1:0]    pc_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic             valid_o,
  output logic [DW-1:0]    data_o,
  output logic [AW-1:0]    pc_o,
  output logic [OCC_W-1:0] occ_o
);

  logic [OCC_W-1:0] occ_q, occ_d;
  logic [DW-1:0]    head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic [AW-1:0]    head_pc_q, head_pc_d, tail_pc_q, tail_pc_d;
  logic             do_pop;

  always_comb begin
    occ_d       = occ_q;
    head_data_d = head_data_q;
    head_pc_d   = head_pc_q;
    tail_data_d = tail_data_q;
    tail_pc_d   = tail_pc_q;
    do_pop      = pop_i && (occ_q != OCC_W'(0));
    if (flush_i) begin
      occ_d = OCC_W'(0);
    end else begin
      case (occ_q)
        OCC_W'(0): begin
          if (push_i) begin
            head_data_d = data_i;
            head_pc_d   = pc_i;
            occ_d       = OCC_W'(1);
          end
        end
        OCC_W'(1): begin
          if (push_i && do_pop) begin
            head_data_d = data_i;
            head_pc_d   = pc_i;
          end else if (push_i) begin
            tail_data_d = data_i;
            tail_pc_d   = pc_i;
            occ_d       = OCC_W'(2);
          end else if (do_pop) begin
            occ_d = OCC_W'(0);
          end
        end
        default: begin
          // Full: a pop promotes the tail, and a simultaneous push refills it.
          if (do_pop) begin
            head_data_d = tail_data_q;
            head_pc_d   = tail_pc_q;
            occ_d       = OCC_W'(1);
            if (push_i) begin
              tail_data_d = data_i;
              tail_pc_d   = pc_i;
              occ_d       = OCC_W'(2);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q       <= OCC_W'(0);
      head_data_q <= '0;
      head_pc_q   <= '0;
      tail_data_q <= '0;
      tail_pc_q   <= '0;
    end else begin
      occ_q       <= occ_d;
      head_data_q <= head_data_d;
      head_pc_q   <= head_pc_d;
      tail_data_q <= tail_data_d;
      tail_pc_q   <= tail_pc_d;
    end
  end

  assign valid_o = (occ_q != OCC_W'(0));
  assign data_o  = head_data_q;
  assign pc_o    = head_pc_q;
  assign occ_o   = occ_q;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: PC, ROM address issue, return tracking and decoder handshake.
// Optional macro FETCH_HALT_EN: an all-ones word halts fetch until a valid redirect.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned data_length = 32,
  parameter int unsigned mem_length  = 32,
  parameter int unsigned RESET_PC    = 0,
  localparam int unsigned AW = (mem_length > 1) ? $clog2(mem_length) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fetch_en,
  output logic [AW-1:0]          rom_address,
  input  logic [data_length-1:0] rom_data,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [data_length-1:0] instr_data,
  output logic [AW-1:0]          instr_pc,
  input  logic                   redirect_valid,
  input  logic [AW-1:0]          redirect_addr,
  output logic                   addr_err,
  output logic                   halted
);

  localparam int unsigned   AW1     = AW + 1;
  localparam logic [AW-1:0] LAST_PC = AW'(mem_length - 1);

  fetch_state_e     state_q;
  logic [AW-1:0]    pc_q, pc_d, rom_address_q, rom_address_d;
  logic             inflight_q, inflight_d;
  logic             inflight_epoch_q, inflight_epoch_d;
  logic             epoch_q, epoch_d;
  logic             addr_err_q, addr_err_d;
  logic [AW:0]      redir_diff_c;
  logic             redir_ok_c, redir_bad_c, accept_c, ret_live_c, push_c, halt_ret_c, issue_c;
  logic [OCC_W-1:0] occ_c, slots_c;

  always_comb begin
    // Sign of (addr - mem_length) gives the range check without a wide compare.
    redir_diff_c = {1'b0, redirect_addr} - AW1'(mem_length);
    redir_ok_c   = redirect_valid && redir_diff_c[AW];
    redir_bad_c  = redirect_valid && !redir_diff_c[AW];
    accept_c     = instr_valid && instr_ready;
    ret_live_c   = inflight_q && (inflight_epoch_q == epoch_q) && (state_q != HALT);
    push_c       = ret_live_c && !redir_ok_c;
`ifdef FETCH_HALT_EN
    halt_ret_c   = push_c && (rom_data == data_length'(HALT_WORD));
`else
    halt_ret_c   = 1'b0;
`endif
    // A word issued now lands next edge; an accept this cycle frees its slot in time.
    slots_c = occ_c - OCC_W'(accept_c) + OCC_W'(inflight_q);
    issue_c = (state_q == RUN) && fetch_en && !redir_ok_c && !halt_ret_c &&
              (slots_c < OCC_W'(BUF_DEPTH));

    pc_d             = pc_q;
    rom_address_d    = rom_address_q;
    inflight_d       = issue_c;
    inflight_epoch_d = epoch_q;
    epoch_d          = epoch_q ^ redir_ok_c;
    addr_err_d       = redir_bad_c;
    if (redir_ok_c) begin
      pc_d = redirect_addr;
    end else if (issue_c) begin
      rom_address_d = pc_q;
      pc_d          = (pc_q == LAST_PC) ? '0 : pc_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q             <= AW'(RESET_PC);
      rom_address_q    <= '0;
      inflight_q       <= 1'b0;
      inflight_epoch_q <= 1'b0;
      epoch_q          <= 1'b0;
      addr_err_q       <= 1'b0;
    end else begin
      pc_q             <= pc_d;
      rom_address_q    <= rom_address_d;
      inflight_q       <= inflight_d;
      inflight_epoch_q <= inflight_epoch_d;
      epoch_q          <= epoch_d;
      addr_err_q       <= addr_err_d;
    end
  end

  // Run/stop state; HALT is only reachable when halt detection is built in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (halt_ret_c)    state_q <= HALT;
          else if (fetch_en) state_q <= RUN;
        end
        RUN: begin
          if (halt_ret_c)     state_q <= HALT;
          else if (!fetch_en) state_q <= IDLE;
        end
        HALT: begin
          if (redir_ok_c) state_q <= fetch_en ? RUN : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  fetch_skid_buf #(
    .DW(data_length),
    .AW(AW)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_c),
    .data_i  (rom_data),
    .pc_i    (rom_address_q),
    .pop_i   (accept_c),
    .flush_i (redir_ok_c),
    .valid_o (instr_valid),
    .data_o  (instr_data),
    .pc_o    (instr_pc),
    .occ_o   (occ_c)
  );

  assign rom_address = rom_address_q;
  assign addr_err    = addr_err_q;
`ifdef FETCH_HALT_EN
  assign halted = (state_q == HALT);
`else
  assign halted = 1'b0;
`endif

endmodule
